prach_unshape: RTL and testbench
================================

Name: prach_unshape

Overview:
- Inverse of the PRACH reshape stage.
- Takes blocks of SIZE samples that arrive as two parallel samples per beat (even sample on dp1, odd sample on dp2) with a channel tag.
- Re-serialises each block to one sample per clock in natural order, carrying the block's channel tag.
- Uses a two-bank ping-pong buffer so the writer can fill one bank while the reader drains the other.
- Sits on the return/output path after the per-channel block processing, feeding single-stream consumers.

Parameters:
- SIZE, 256, samples per block; power of two, minimum 4.
- WIDTH, 16, sample width in bits.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- din_dp1  in  WIDTH  even-index sample (2k) of the current beat
- din_dp2  in  WIDTH  odd-index sample (2k+1) of the current beat
- din_dv  in  1  beat valid
- din_chn  in  8  channel tag; sampled on beat 0 of each block
- sync_in  in  1  frame sync; restarts block alignment
- dout_dq  out  WIDTH  serial sample
- dout_dv  out  1  sample valid
- dout_chn  out  8  tag of the block being output
- sync_out  out  1  one-cycle pulse on the first valid sample after a sync
- overflow  out  1  one-cycle pulse when a completed input block is dropped

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high.
- Reset values: dout_dq=0, dout_dv=0, dout_chn=0, sync_out=0, overflow=0. Both banks empty, write count 0, reader IDLE, sync-pending flag clear.
- Storage: 2 banks × SIZE/2 words of 2*WIDTH bits, word = {dp2, dp1}. RAM has 1-cycle read latency.
- Writer:
  - Each beat with din_dv=1 writes word wcnt (0..SIZE/2-1) into the current write bank; wcnt increments.
  - On beat 0, din_chn is latched as that bank's tag.
  - On beat SIZE/2-1 the bank is marked full, the write bank toggles and wcnt wraps to 0.
- Writer overflow:
  - If both banks are full (or the target is being read) when beat 0 of a new block arrives, the whole block is discarded.
  - Beats are counted but not written.
  - overflow pulses for 1 cycle on that block's last beat. Bank state is unchanged.
- Reader FSM:
  - IDLE: go to READ when the bank at the read pointer is full.
  - READ:
    - rcnt runs 0..SIZE-1.
    - RAM address = rcnt>>1.
    - Output mux selects dp1 when rcnt is even, dp2 when odd, using rcnt[0] delayed by the RAM latency.
  - At rcnt=SIZE-1: the bank is freed and the read pointer toggles.
    - If the other bank is already full, stay in READ with rcnt=0 (back-to-back blocks, no dout_dv gap).
    - Otherwise return to IDLE.
- Latency: the last input beat of a block at cycle N gives its first dout_dv at cycle N+3 (full flag N+1, RAM read N+2, output register N+3), when the reader was IDLE.
- Output: dout_dv is high for exactly SIZE consecutive cycles per block. dout_chn holds the bank tag for all of them. dout_dq holds its last value when dout_dv=0.
- Throughput: sustained input duty cycle must be ≤50%. Bursts of up to 2 blocks at full rate are absorbed.
- sync_in=1:
  - Next cycle: wcnt=0, both banks empty, reader forced to IDLE, dout_dv=0, sync-pending set.
  - A din_dv beat in the same cycle as sync_in is taken as beat 0 of the new block.
  - sync_out pulses with the first dout_dv after sync-pending is set, which then clears.
  - sync_in during reset is ignored.
- din_chn changing mid-block is ignored; the beat-0 tag wins.
- Reset mid-read: output stops the next cycle and all buffered data is lost.

Decomposition:
- Shared package prach_pkg holds:
  - WIDTH default;
  - chn_t (8-bit channel tag type);
  - bank-state enum {EMPTY, FULL};
  - reader-state enum {IDLE, READ}.
- One sub-module, prach_unshape_ram: simple dual-port RAM, 1 write port, 1 registered read port, depth SIZE, 2*WIDTH wide, no reset on the array.
- The top module contains the writer counter, bank flags, reader FSM and output mux.

Test Plan:
- Single block, SIZE=256: 128 consecutive beats with dp1=2k, dp2=2k+1, chn=5 → dout_dq=0..255 in order, dout_chn=5, first dout_dv 3 cycles after the last beat, 256 consecutive valids, no overflow.
- Two blocks at 50% duty (beat every other cycle), chn 3 then 9 → 512 consecutive dout_dv with no gap; tag 3 for samples 0–255, then 9.
- Three blocks back-to-back at full rate (chn 1, 2, 3) → blocks 1 and 2 output correctly; block 3 dropped; overflow pulses once on block 3's last beat.
- sync_in after 40 beats of a block, then a fresh 128-beat block with chn=7 → partial block never output; sync_out coincides with the first output sample (value 0, chn 7).
- Assert rst for 1 cycle at output sample 100 → dout_dv=0 on the next cycle, all outputs at reset values; a following full block is output normally.
- Change din_chn from 4 to 6 at beat 60 of a block → all 256 outputs carry dout_chn=4.

Source files
------------

// File: rtl/prach_pkg.sv
// prach_pkg: types shared by the PRACH unshape slice.
// Holds the default sample width, channel tag type and state encodings.
package prach_pkg;

    localparam int WIDTH_DEF = 16;

    typedef logic [7:0] chn_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } bank_state_e;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } rd_state_e;

endpackage

// File: rtl/prach_unshape_if.sv
// prach_unshape_if: two-sample input beat bus and serial output bus.
// master drives din_*/sync_in and takes dout_*; slave is the unshaper side.
interface prach_unshape_if #(
    parameter int WIDTH = prach_pkg::WIDTH_DEF
) ();
    import prach_pkg::*;

    logic [WIDTH-1:0] din_dp1;
    logic [WIDTH-1:0] din_dp2;
    logic             din_dv;
    chn_t             din_chn;
    logic             sync_in;
    logic [WIDTH-1:0] dout_dq;
    logic             dout_dv;
    chn_t             dout_chn;
    logic             sync_out;
    logic             overflow;

    modport master (
        output din_dp1, din_dp2, din_dv, din_chn, sync_in,
        input  dout_dq, dout_dv, dout_chn, sync_out, overflow
    );

    modport slave (
        input  din_dp1, din_dp2, din_dv, din_chn, sync_in,
        output dout_dq, dout_dv, dout_chn, sync_out, overflow
    );

endinterface

// File: rtl/prach_unshape_ram.sv
// prach_unshape_ram: simple dual-port RAM, one write port, registered read.
// Ports: clk, we/waddr/wdata write side, re/raddr/rdata read side.
module prach_unshape_ram #(
    parameter int DEPTH = 256,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DW-1:0]            wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DW-1:0]            rdata
);
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/prach_unshape.sv
// prach_unshape: two-bank ping-pong re-serialiser, 2 samples/beat in, 1 out.
// Ports: clk, rst (sync, active high), bus (slave: din_*/sync_in, dout_*).
module prach_unshape
    import prach_pkg::*;
#(
    parameter int SIZE  = 256,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic           clk,
    input  logic           rst,
    prach_unshape_if.slave bus
);
    localparam int AW = $clog2(SIZE);
    localparam int WW = AW - 1;
    localparam logic [WW-1:0] WLAST = WW'(SIZE / 2 - 1);
    localparam logic [AW-1:0] RLAST = AW'(SIZE - 1);

    logic [WW-1:0]    wcnt_q, wcnt_d;
    logic             wbank_q, wbank_d;
    logic             drop_q, drop_d;
    bank_state_e      bank_q [2];
    bank_state_e      bank_d [2];
    chn_t             tag_q [2];
    chn_t             tag_d [2];
    rd_state_e        rd_q, rd_d;
    logic [AW-1:0]    rcnt_q, rcnt_d;
    logic             rptr_q, rptr_d;
    logic             v1_q, v1_d;
    logic             sel_q, sel_d;
    chn_t             chn1_q, chn1_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] dq_q, dq_d;
    logic             dv_q, dv_d;
    chn_t             chn_q, chn_d;
    logic             so_q, so_d;
    logic             ovf_q, ovf_d;

    logic             sync;
    logic [WW-1:0]    wcnt_e;
    logic             wbank_e;
    logic             tgt_full;
    logic             drop;
    logic             we;
    logic             re;
    logic [2*WIDTH-1:0] rdata;

    always_comb begin
        sync    = bus.sync_in;
        wcnt_d  = wcnt_q;
        wbank_d = wbank_q;
        drop_d  = drop_q;
        bank_d  = bank_q;
        tag_d   = tag_q;
        rd_d    = rd_q;
        rcnt_d  = rcnt_q;
        rptr_d  = rptr_q;
        ovf_d   = 1'b0;
        we      = 1'b0;
        re      = 1'b0;
        // A sync empties both banks; a beat in the same cycle is beat 0.
        wcnt_e   = sync ? '0 : wcnt_q;
        wbank_e  = sync ? 1'b0 : wbank_q;
        tgt_full = !sync && (bank_q[wbank_q] == FULL);
        // Drop decision is taken on beat 0 and held for the whole block.
        drop     = (wcnt_e == '0) ? tgt_full : drop_q;

        if (sync) begin
            wcnt_d  = '0;
            wbank_d = 1'b0;
            drop_d  = 1'b0;
            bank_d  = '{EMPTY, EMPTY};
            rd_d    = IDLE;
            rcnt_d  = '0;
            rptr_d  = 1'b0;
        end else begin
            // IDLE issues read 0 the cycle it sees a full bank.
            re = (rd_q == READ) || (bank_q[rptr_q] == FULL);
            if (re) begin
                if (rcnt_q == RLAST) begin
                    bank_d[rptr_q] = EMPTY;
                    rptr_d = !rptr_q;
                    rcnt_d = '0;
                    rd_d   = (bank_q[!rptr_q] == FULL) ? READ : IDLE;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                    rd_d   = READ;
                end
            end
        end

        if (bus.din_dv) begin
            we     = !drop;
            drop_d = drop;
            if (wcnt_e == '0 && !drop) begin
                tag_d[wbank_e] = bus.din_chn;
            end
            if (wcnt_e == WLAST) begin
                wcnt_d = '0;
                ovf_d  = drop;
                if (!drop) begin
                    bank_d[wbank_e] = FULL;
                    wbank_d = !wbank_e;
                end
            end else begin
                wcnt_d = wcnt_e + 1'b1;
            end
        end

        // Stage 1 tracks the RAM read; stage 2 is the output register.
        v1_d   = re;
        sel_d  = rcnt_q[0];
        chn1_d = tag_q[rptr_q];
        dv_d   = v1_q && !sync;
        so_d   = dv_d && pend_q;
        pend_d = sync || (pend_q && !v1_q);
        dq_d   = dq_q;
        chn_d  = chn_q;
        if (dv_d) begin
            dq_d  = sel_q ? rdata[2*WIDTH-1:WIDTH] : rdata[WIDTH-1:0];
            chn_d = chn1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q  <= '0;
            wbank_q <= 1'b0;
            drop_q  <= 1'b0;
            bank_q  <= '{EMPTY, EMPTY};
            tag_q   <= '{default: '0};
            rd_q    <= IDLE;
            rcnt_q  <= '0;
            rptr_q  <= 1'b0;
            v1_q    <= 1'b0;
            sel_q   <= 1'b0;
            chn1_q  <= '0;
            pend_q  <= 1'b0;
            dq_q    <= '0;
            dv_q    <= 1'b0;
            chn_q   <= '0;
            so_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wcnt_q  <= wcnt_d;
            wbank_q <= wbank_d;
            drop_q  <= drop_d;
            bank_q  <= bank_d;
            tag_q   <= tag_d;
            rd_q    <= rd_d;
            rcnt_q  <= rcnt_d;
            rptr_q  <= rptr_d;
            v1_q    <= v1_d;
            sel_q   <= sel_d;
            chn1_q  <= chn1_d;
            pend_q  <= pend_d;
            dq_q    <= dq_d;
            dv_q    <= dv_d;
            chn_q   <= chn_d;
            so_q    <= so_d;
            ovf_q   <= ovf_d;
        end
    end

    prach_unshape_ram #(
        .DEPTH (SIZE),
        .DW    (2 * WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr ({wbank_e, wcnt_e}),
        .wdata ({bus.din_dp2, bus.din_dp1}),
        .re    (re),
        .raddr ({rptr_q, rcnt_q[AW-1:1]}),
        .rdata (rdata)
    );

    assign bus.dout_dq  = dq_q;
    assign bus.dout_dv  = dv_q;
    assign bus.dout_chn = chn_q;
    assign bus.sync_out = so_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_prach_unshape.sv
// tb_prach_unshape: directed vectors for prach_unshape (SIZE=256, WIDTH=16).
// Drives beats after posedge, samples outputs on negedge.
module tb_prach_unshape;
    import prach_pkg::*;

    localparam int SIZE  = 256;
    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prach_unshape_if #(.WIDTH(WIDTH)) bus ();

    prach_unshape #(
        .SIZE  (SIZE),
        .WIDTH (WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [WIDTH-1:0] q_dq[$];
    chn_t             q_chn[$];
    int               q_cyc[$];
    int               n_so = 0;
    int               so_cyc = -1;
    int               n_ovf = 0;
    int               ovf_cyc = -1;

    logic [WIDTH-1:0] e_dq[$];
    chn_t             e_chn[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.dout_dv === 1'b1) begin
            q_dq.push_back(bus.dout_dq);
            q_chn.push_back(bus.dout_chn);
            q_cyc.push_back(cyc);
        end
        if (bus.sync_out === 1'b1) begin
            n_so++;
            so_cyc = cyc;
        end
        if (bus.overflow === 1'b1) begin
            n_ovf++;
            ovf_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input integer got, input integer exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_block(input chn_t c, input int base, input int gap,
                              input int sw_at, input chn_t c2,
                              input logic sync0, input int nbeats,
                              output int last);
        last = -1;
        for (int k = 0; k < nbeats; k++) begin
            bus.din_dv  = 1'b1;
            bus.din_dp1 = WIDTH'(base + 2 * k);
            bus.din_dp2 = WIDTH'(base + 2 * k + 1);
            bus.din_chn = (sw_at >= 0 && k >= sw_at) ? c2 : c;
            bus.sync_in = sync0 && (k == 0);
            last = cyc;
            @(posedge clk);
            #1;
            bus.din_dv  = 1'b0;
            bus.sync_in = 1'b0;
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic exp_add(input int base, input chn_t c, input int n);
        for (int i = 0; i < n; i++) begin
            e_dq.push_back(WIDTH'(base + i));
            e_chn.push_back(c);
        end
    endtask

    task automatic check_stream(input string t, input int b0);
        int bad_d;
        int bad_c;
        int gaps;
        bad_d = 0;
        bad_c = 0;
        gaps  = 0;
        chk({t, "_cnt"}, q_dq.size() - b0, e_dq.size());
        for (int i = 0; i < e_dq.size() && b0 + i < q_dq.size(); i++) begin
            if (q_dq[b0 + i] !== e_dq[i]) bad_d++;
            if (q_chn[b0 + i] !== e_chn[i]) bad_c++;
            if (i > 0 && q_cyc[b0 + i] != q_cyc[b0 + i - 1] + 1) gaps++;
        end
        chk({t, "_data"}, bad_d, 0);
        chk({t, "_chn"}, bad_c, 0);
        chk({t, "_gaps"}, gaps, 0);
    endtask

    function automatic int first_cyc(input int b0);
        return (q_cyc.size() > b0) ? q_cyc[b0] : -1000;
    endfunction

    initial begin
        int b0;
        int last;
        int last2;
        int so0;
        int ovf0;
        int found;

        bus.din_dv  = 1'b0;
        bus.din_dp1 = '0;
        bus.din_dp2 = '0;
        bus.din_chn = '0;
        bus.sync_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dv", 32'(bus.dout_dv), 0);
        chk("rst_dq", 32'(bus.dout_dq), 0);
        chk("rst_chn", 32'(bus.dout_chn), 0);
        chk("rst_sync", 32'(bus.sync_out), 0);
        chk("rst_ovf", 32'(bus.overflow), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.sync_in = 1'b0;
        idle(2);

        // single block, full rate
        b0 = q_dq.size();
        ovf0 = n_ovf;
        so0 = n_so;
        send_block(8'd5, 0, 0, -1, 8'd0, 1'b0, 128, last);
        idle(300);
        e_dq.delete();
        e_chn.delete();
        exp_add(0, 8'd5, 256);
        check_stream("t1", b0);
        chk("t1_lat", first_cyc(b0) - last, 3);
        chk("t1_ovf", n_ovf - ovf0, 0);
        chk("t1_sync", n_so - so0, 0);

        // two blocks at 50% duty
        b0 = q_dq.size();
        send_block(8'd3, 0, 1, -1, 8'd0, 1'b0, 128, last);
        send_block(8'd9, 256, 1, -1, 8'd0, 1'b0, 128, last2);
        idle(600);
        e_dq.delete();
        e_chn.delete();
        exp_add(0, 8'd3, 256);
        exp_add(256, 8'd9, 256);
        check_stream("t2", b0);
        chk("t2_lat", first_cyc(b0) - last, 3);

        // three blocks back to back, third dropped
        b0 = q_dq.size();
        ovf0 = n_ovf;
        send_block(8'd1, 0, 0, -1, 8'd0, 1'b0, 128, last);
        send_block(8'd2, 1000, 0, -1, 8'd0, 1'b0, 128, last);
        send_block(8'd3, 2000, 0, -1, 8'd0, 1'b0, 128, last);
        idle(600);
        e_dq.delete();
        e_chn.delete();
        exp_add(0, 8'd1, 256);
        exp_add(1000, 8'd2, 256);
        check_stream("t3", b0);
        chk("t3_ovf_cnt", n_ovf - ovf0, 1);
        chk("t3_ovf_cyc", ovf_cyc - last, 1);

        // partial block cut by sync, fresh block on the sync beat
        b0 = q_dq.size();
        so0 = n_so;
        send_block(8'd11, 3000, 0, -1, 8'd0, 1'b0, 40, last);
        send_block(8'd7, 0, 0, -1, 8'd0, 1'b1, 128, last);
        idle(300);
        e_dq.delete();
        e_chn.delete();
        exp_add(0, 8'd7, 256);
        check_stream("t4", b0);
        chk("t4_so_cnt", n_so - so0, 1);
        chk("t4_so_cyc", so_cyc, first_cyc(b0));

        // reset at output sample 100
        b0 = q_dq.size();
        send_block(8'd8, 0, 0, -1, 8'd0, 1'b0, 128, last);
        found = 0;
        for (int t = 0; t < 600 && found == 0; t++) begin
            @(negedge clk);
            if (bus.dout_dv === 1'b1 && bus.dout_dq === 16'd100) found = 1;
        end
        chk("t5_hit", found, 1);
        if (found == 1) begin
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            @(negedge clk);
            chk("t5_dv", 32'(bus.dout_dv), 0);
            chk("t5_dq", 32'(bus.dout_dq), 0);
            chk("t5_chn", 32'(bus.dout_chn), 0);
        end
        @(posedge clk);
        #1;
        idle(20);
        e_dq.delete();
        e_chn.delete();
        exp_add(0, 8'd8, 101);
        check_stream("t5a", b0);
        b0 = q_dq.size();
        send_block(8'd12, 500, 0, -1, 8'd0, 1'b0, 128, last);
        idle(300);
        e_dq.delete();
        e_chn.delete();
        exp_add(500, 8'd12, 256);
        check_stream("t5b", b0);
        chk("t5b_lat", first_cyc(b0) - last, 3);

        // tag change mid block is ignored
        b0 = q_dq.size();
        send_block(8'd4, 0, 0, 60, 8'd6, 1'b0, 128, last);
        idle(300);
        e_dq.delete();
        e_chn.delete();
        exp_add(0, 8'd4, 256);
        check_stream("t6", b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
